// File: rtl/flag_arb_pkg.sv
// Shared types and defaults for the status-flag write arbiter.
// Imported by the arbiter top and its round-robin picker.
package flag_arb_pkg;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_t;

    localparam int DEF_NUM_FLAGS = 4;
    localparam int DEF_NUM_REQ   = 2;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/flag_arb_if.sv
// Requester-side handshake bundle for the flag write arbiter.
// Per-requester fields are packed requester-major, NUM_FLAGS bits each.
interface flag_arb_if #(
    parameter int NUM_REQ   = 2,
    parameter int NUM_FLAGS = 4
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*NUM_FLAGS-1:0] req_mask;
    logic [NUM_REQ*NUM_FLAGS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_lock;
    logic [NUM_REQ-1:0]           req_ready;

    modport master (
        output req_valid,
        output req_mask,
        output req_data,
        output req_lock,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_mask,
        input  req_data,
        input  req_lock,
        output req_ready
    );

endinterface

// File: rtl/flag_arb_rr_pick.sv
// Combinational round-robin picker: first valid at or after ptr.
// Produces a one-hot grant plus its encoded index.
module flag_arb_rr_pick #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && valid[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/flag_write_arbiter.sv
// Round-robin arbiter with atomic lock for the status-flag bank.
// Write strobes are registered so they settle before the bank's falling-edge sample.
module flag_write_arbiter
    import flag_arb_pkg::*;
#(
    parameter  int NUM_FLAGS    = DEF_NUM_FLAGS,
    parameter  int NUM_REQ      = DEF_NUM_REQ,
    parameter  int LOCK_TIMEOUT = 15,
    localparam int PW = $clog2(NUM_REQ),
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    flag_arb_if.slave            req,
    output logic [NUM_FLAGS-1:0] flag_write,
    output logic [NUM_FLAGS-1:0] flag_wdata,
    output logic                 locked,
    output logic [PW-1:0]        owner,
    output logic                 lock_err
);

    arb_state_t    state, state_n;
    logic [PW-1:0] ptr, ptr_n, owner_n;
    logic [TW-1:0] timer, timer_n;
    logic          err_n;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;
    logic [NUM_REQ-1:0]   ready;
    logic                 xfer;
    logic [PW-1:0]        xfer_idx;
    logic [NUM_FLAGS-1:0] sel_mask;
    logic [NUM_FLAGS-1:0] sel_data;

    flag_arb_rr_pick #(.N(NUM_REQ)) u_pick (
        .valid     (req.req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign req.req_ready = ready;
    assign locked        = (state == LOCKED);
    assign sel_mask = req.req_mask[xfer_idx*NUM_FLAGS +: NUM_FLAGS];
    assign sel_data = req.req_data[xfer_idx*NUM_FLAGS +: NUM_FLAGS];

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        timer_n  = timer;
        err_n    = 1'b0;
        ready    = '0;
        xfer     = 1'b0;
        xfer_idx = owner;
        unique case (state)
            ARB: begin
                if (pick_any) begin
                    ready    = pick_grant;
                    xfer     = 1'b1;
                    xfer_idx = pick_idx;
                    owner_n  = pick_idx;
                    ptr_n    = PW'(wrap_inc(int'(pick_idx), NUM_REQ));
                    if (req.req_lock[pick_idx]) begin
                        state_n = LOCKED;
                        timer_n = '0;
                    end
                end
            end
            LOCKED: begin
                if (req.req_valid[owner]) begin
                    ready[owner] = 1'b1;
                    xfer         = 1'b1;
                    ptr_n   = PW'(wrap_inc(int'(owner), NUM_REQ));
                    timer_n = '0;
                    if (!req.req_lock[owner]) state_n = ARB;
                end else if (LOCK_TIMEOUT != 0) begin
                    // this idle cycle is the LOCK_TIMEOUT-th one
                    if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                        state_n = ARB;
                        err_n   = 1'b1;
                        timer_n = '0;
                        ptr_n   = PW'(wrap_inc(int'(owner), NUM_REQ));
                    end else if (timer != '1) begin
                        timer_n = timer + 1'b1;
                    end
                end
            end
            default: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            owner      <= '0;
            timer      <= '0;
            lock_err   <= 1'b0;
            flag_write <= '0;
            flag_wdata <= '0;
        end else begin
            ptr        <= ptr_n;
            owner      <= owner_n;
            timer      <= timer_n;
            lock_err   <= err_n;
            flag_write <= xfer ? sel_mask : '0;
            flag_wdata <= xfer ? (sel_data & sel_mask) : '0;
        end
    end

endmodule

// File: tb/tb_flag_write_arbiter.sv
// Randomised and directed bench for flag_write_arbiter.
// A transaction-level reference model predicts grants and bank writes.
module tb_flag_write_arbiter;

    localparam int NR = 2;
    localparam int NF = 4;
    localparam int TO = 15;
    localparam int VW = NR + NF + NF + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flag_arb_if #(.NUM_REQ(NR), .NUM_FLAGS(NF)) bus ();

    logic [NF-1:0] fw, wd;
    logic          locked, lock_err;
    logic          owner;

    logic [NR-1:0]         valid;
    logic [NR-1:0][NF-1:0] mask;
    logic [NR-1:0][NF-1:0] data;
    logic [NR-1:0]         lock;

    assign bus.req_valid = valid;
    assign bus.req_mask  = mask;
    assign bus.req_data  = data;
    assign bus.req_lock  = lock;

    flag_write_arbiter #(
        .NUM_FLAGS(NF), .NUM_REQ(NR), .LOCK_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.slave),
        .flag_write (fw),
        .flag_wdata (wd),
        .locked     (locked),
        .owner      (owner),
        .lock_err   (lock_err)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    bit            m_locked;
    int            m_ptr, m_owner, m_idle;
    logic [NF-1:0] m_fw, m_wd;
    bit            m_err;

    logic [NR-1:0] obs_ready, exp_ready;
    logic [VW-1:0] obs_vec, exp_vec;

    task automatic model_reset();
        m_locked = 0; m_ptr = 0; m_owner = 0; m_idle = 0;
        m_fw = '0; m_wd = '0; m_err = 0;
    endtask

    task automatic idle_inputs();
        valid = '0; mask = '0; data = '0; lock = '0;
    endtask

    // one clock: predict ready, sample it, clock, advance model
    task automatic tick();
        int w;
        w = -1;
        #1;
        if (!m_locked) begin
            for (int k = 0; k < NR; k++)
                if (w < 0 && valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        end else if (valid[m_owner]) begin
            w = m_owner;
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        obs_ready = bus.req_ready;
        @(posedge clk);
        m_err = 0; m_fw = '0; m_wd = '0;
        if (w >= 0) begin
            m_fw = mask[w];
            m_wd = data[w] & mask[w];
            m_owner = w;
            m_ptr = (w + 1) % NR;
            m_idle = 0;
            m_locked = lock[w];
        end else if (m_locked) begin
            m_idle++;
            if (TO > 0 && m_idle == TO) begin
                m_locked = 0; m_err = 1; m_idle = 0;
                m_ptr = (m_owner + 1) % NR;
            end
        end
        #1;
        exp_vec = {exp_ready, m_fw, m_wd, m_locked, m_err, 1'(m_owner)};
        obs_vec = {obs_ready, fw, wd, locked, lock_err, owner};
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({fw, wd, locked, lock_err, owner} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {fw, wd, locked, lock_err, owner});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        valid[0] = 1'b1; mask[0] = 4'b1111; data[0] = 4'b1010;
        tick();
        checks++;
        if (obs_ready !== 2'b01 || fw !== 4'b1111 || wd !== 4'b1010) begin
            errors++;
            $display("FAIL single_write ready=%b fw=%b wd=%b exp 01/1111/1010",
                     obs_ready, fw, wd);
        end
        idle_inputs();
        tick();
        checks++;
        if (fw !== 4'b0000 || wd !== 4'b0000) begin
            errors++;
            $display("FAIL single_after fw=%b wd=%b exp 0000/0000", fw, wd);
        end
    endtask

    task automatic test_alternate();
        logic [NR-1:0] prev;
        valid = 2'b11; mask[0] = 4'b0011; mask[1] = 4'b1100;
        data[0] = 4'b0001; data[1] = 4'b1000;
        prev = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL alternate cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            checks++;
            if (fw === 4'b0000 || (c > 0 && obs_ready === prev)) begin
                errors++;
                $display("FAIL alternate_pattern cyc=%0d ready=%b prev=%b fw=%b",
                         c, obs_ready, prev, fw);
            end
            prev = obs_ready;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock_hold();
        valid = 2'b11; lock = 2'b10;
        mask[0] = 4'b0001; mask[1] = 4'b0110; data = '1;
        for (int c = 0; c < 4 && !m_locked; c++) tick();
        checks++;
        if (!m_locked || locked !== 1'b1 || owner !== 1'b1) begin
            errors++;
            $display("FAIL lock_acquire locked=%b owner=%b exp 1/1", locked, owner);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs_ready !== 2'b10 || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL lock_hold cyc=%0d ready=%b got=%h exp=%h",
                         c, obs_ready, obs_vec, exp_vec);
            end
        end
        lock[1] = 1'b0;
        tick();
        checks++;
        if (obs_ready !== 2'b10 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_release ready=%b locked=%b exp 10/0", obs_ready, locked);
        end
        valid[1] = 1'b0;
        tick();
        checks++;
        if (obs_ready !== 2'b01 || fw !== 4'b0001) begin
            errors++;
            $display("FAIL lock_next ready=%b fw=%b exp 01/0001", obs_ready, fw);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int err_cyc;
        valid[0] = 1'b1; lock[0] = 1'b1; mask[0] = 4'b0100;
        tick();
        idle_inputs();
        err_cyc = -1;
        for (int c = 1; c <= TO + 2; c++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (lock_err === 1'b1) err_cyc = c;
        end
        checks++;
        if (err_cyc != TO || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse at=%0d exp=%0d locked=%b", err_cyc, TO, locked);
        end
    endtask

    task automatic test_mask_zero();
        valid[1] = 1'b1; mask[1] = 4'b0000; data[1] = 4'b1111;
        tick();
        checks++;
        if (obs_ready !== 2'b10 || fw !== 4'b0000 || wd !== 4'b0000) begin
            errors++;
            $display("FAIL mask_zero ready=%b fw=%b wd=%b exp 10/0000/0000",
                     obs_ready, fw, wd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_expiry_race();
        valid[0] = 1'b1; lock[0] = 1'b1; mask[0] = 4'b1001; data[0] = 4'b1111;
        tick();
        idle_inputs();
        for (int c = 1; c < TO; c++) tick();
        valid[0] = 1'b1; lock[0] = 1'b1; mask[0] = 4'b0010; data[0] = 4'b0010;
        tick();
        checks++;
        if (obs_ready !== 2'b01 || lock_err !== 1'b0 || locked !== 1'b1 || fw !== 4'b0010) begin
            errors++;
            $display("FAIL expiry_race ready=%b err=%b locked=%b fw=%b exp 01/0/1/0010",
                     obs_ready, lock_err, locked, fw);
        end
        lock[0] = 1'b0;
        tick();
        checks++;
        if (obs_vec !== exp_vec || locked !== 1'b0) begin
            errors++;
            $display("FAIL expiry_release got=%h exp=%h", obs_vec, exp_vec);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_lock();
        valid[0] = 1'b1; lock[0] = 1'b1; mask[0] = 4'b1111; data[0] = 4'b0110;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({fw, wd, locked, lock_err, owner} !== '0) begin
            errors++;
            $display("FAIL reset_mid_lock got=%h exp=0", {fw, wd, locked, lock_err, owner});
        end
        model_reset();
        #2;
        rst = 1'b0;
        idle_inputs();
        valid = 2'b11; mask[0] = 4'b0001; mask[1] = 4'b0010; data = '1;
        tick();
        checks++;
        if (obs_ready !== 2'b01 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_ptr got=%h exp=%h", obs_vec, exp_vec);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                valid[i] = ($urandom_range(0, 2) != 0);
                lock[i]  = ($urandom_range(0, 3) == 0);
                mask[i]  = NF'($urandom);
                data[i]  = NF'($urandom);
            end
            // long idle stretches let held locks run into the timeout
            if ($urandom_range(0, 15) == 0) begin
                idle_inputs();
                for (int k = 0; k < 16; k++) begin
                    tick();
                    checks++;
                    if (obs_vec !== exp_vec) begin
                        errors++;
                        $display("FAIL random_idle cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
                    end
                end
            end else begin
                tick();
                checks++;
                if (obs_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock_hold();
        test_timeout();
        test_mask_zero();
        test_expiry_race();
        test_reset_mid_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
